mc14433_bcd_reader: RTL and testbench

Receive-side decoder for the MC14433 converter's multiplexed BCD output. It watches the EOC pulse, the digit strobes DS1..DS4 and the shared data nibble Q, and reassembles one complete 3½-digit reading per conversion. The reading is presented as BCD digits, sign and range flags, and an 11-bit binary magnitude. It sits downstream of the converter core, on the same CP0 clock, and feeds display and host logic.

---
 rtl/mc14433_bcd_reader.sv | 173 +++++++++++++++++
 tb/tb_mc14433_bcd_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc14433_bcd_reader.sv
// mc14433_bcd_reader: rebuilds one 3.5-digit MC14433 reading per conversion from the
// multiplexed DS1..DS4 strobes and Q nibble, with sequence, BCD and timeout checking.
module mc14433_bcd_reader #(
    parameter int TIMEOUT = 4096
) (
    input  logic        CP0,
    input  logic        R_clock,
    input  logic        EOC,
    input  logic [4:1]  DS,
    input  logic [3:0]  Q,
    output logic        HALF,
    output logic [3:0]  D2,
    output logic [3:0]  D3,
    output logic [3:0]  D4,
    output logic        POS,
    output logic        OVR,
    output logic        UDR,
    output logic [10:0] MAG,
    output logic        VALID,
    output logic        ERR
);
    typedef enum logic [2:0] {IDLE, ARMED, S1, S2, S3} state_t;
    state_t      r_state, w_next;
    logic        r_eoc_m, r_eoc_s, r_eoc_d;
    logic [4:1]  r_ds_m, r_ds_s, r_ds_d;
    logic [3:0]  r_q_m, r_q_s;
    logic [15:0] r_cnt;
    logic        r_s_half, r_s_pos, r_s_ovr, r_s_udr;
    logic [3:0]  r_s_d2, r_s_d3;
    logic        r_half, r_pos, r_ovr, r_udr, r_valid, r_err;
    logic [3:0]  r_d2, r_d3, r_d4;
    logic [10:0] r_mag;
    logic        w_eoc_rise, w_multi, w_bad_bcd, w_timeout, w_in_frame, w_ok;
    logic [4:1]  w_ds_rise, w_exp;
    logic        w_err, w_commit, w_cap1, w_cap2, w_cap3;
    logic [10:0] w_mag;

    always_ff @(posedge CP0) begin
        if (!R_clock) begin
            r_eoc_m <= 1'b0;
            r_eoc_s <= 1'b0;
            r_eoc_d <= 1'b0;
            r_ds_m  <= '0;
            r_ds_s  <= '0;
            r_ds_d  <= '0;
            r_q_m   <= '0;
            r_q_s   <= '0;
        end else begin
            r_eoc_m <= EOC;
            r_eoc_s <= r_eoc_m;
            r_eoc_d <= r_eoc_s;
            r_ds_m  <= DS;
            r_ds_s  <= r_ds_m;
            r_ds_d  <= r_ds_s;
            r_q_m   <= Q;
            r_q_s   <= r_q_m;
        end
    end

    assign w_eoc_rise = r_eoc_s & ~r_eoc_d;
    assign w_ds_rise  = r_ds_s & ~r_ds_d;
    // Clearing the lowest set bit leaves something only if two or more strobes are high
    assign w_multi    = (r_ds_s & (r_ds_s - 4'd1)) != 4'd0;
    assign w_bad_bcd  = r_q_s > 4'd9;
    assign w_timeout  = r_cnt == 16'(TIMEOUT - 1);
    assign w_in_frame = (r_state == S1) || (r_state == S2) || (r_state == S3);
    assign w_exp      = (r_state == S1) ? 4'b0010 : (r_state == S2) ? 4'b0100 : 4'b1000;
    assign w_ok       = (w_ds_rise == w_exp) && !w_multi && !w_bad_bcd;

    always_ff @(posedge CP0) begin
        if (!R_clock) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_in_frame && w_next == r_state) ? r_cnt + 16'd1 : 16'd0;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_err    = 1'b0;
        w_commit = 1'b0;
        w_cap1   = 1'b0;
        w_cap2   = 1'b0;
        w_cap3   = 1'b0;
        case (r_state)
            IDLE: w_next = w_eoc_rise ? ARMED : IDLE;
            ARMED: begin
                if (!w_eoc_rise && w_ds_rise[1]) begin
                    w_err  = w_multi;
                    w_cap1 = !w_multi;
                    w_next = w_multi ? IDLE : S1;
                end
            end
            default: begin
                // A good DS4 commit takes priority over a simultaneous EOC restart
                if (r_state == S3 && w_ok) begin
                    w_commit = 1'b1;
                    w_next   = w_eoc_rise ? ARMED : IDLE;
                end else if (w_eoc_rise) begin
                    w_next = ARMED;
                end else if (|w_ds_rise) begin
                    w_err  = !w_ok;
                    w_cap2 = w_ok && r_state == S1;
                    w_cap3 = w_ok && r_state == S2;
                    w_next = !w_ok ? IDLE : (r_state == S1) ? S2 : S3;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
            end
        endcase
    end

    // x100 = x64 + x32 + x4, x10 = x8 + x2; D4 comes straight from the committing nibble
    assign w_mag = (r_s_half ? 11'd1000 : 11'd0)
                 + 11'({r_s_d2, 6'd0}) + 11'({r_s_d2, 5'd0}) + 11'({r_s_d2, 2'd0})
                 + 11'({r_s_d3, 3'd0}) + 11'({r_s_d3, 1'd0}) + 11'(r_q_s);

    always_ff @(posedge CP0) begin
        if (!R_clock) begin
            r_s_half <= 1'b0;
            r_s_pos  <= 1'b0;
            r_s_ovr  <= 1'b0;
            r_s_udr  <= 1'b0;
            r_s_d2   <= '0;
            r_s_d3   <= '0;
            r_half   <= 1'b0;
            r_pos    <= 1'b0;
            r_ovr    <= 1'b0;
            r_udr    <= 1'b0;
            r_d2     <= '0;
            r_d3     <= '0;
            r_d4     <= '0;
            r_mag    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= w_commit;
            r_err   <= w_err;
            if (w_cap1) begin
                r_s_half <= ~r_q_s[3];
                r_s_pos  <= r_q_s[2];
                r_s_ovr  <= r_q_s[0] & ~r_q_s[3];
                r_s_udr  <= r_q_s[0] & r_q_s[3];
            end
            if (w_cap2) r_s_d2 <= r_q_s;
            if (w_cap3) r_s_d3 <= r_q_s;
            if (w_commit) begin
                r_half <= r_s_half;
                r_pos  <= r_s_pos;
                r_ovr  <= r_s_ovr;
                r_udr  <= r_s_udr;
                r_d2   <= r_s_d2;
                r_d3   <= r_s_d3;
                r_d4   <= r_q_s;
                r_mag  <= w_mag;
            end
        end
    end

    assign HALF  = r_half;
    assign POS   = r_pos;
    assign OVR   = r_ovr;
    assign UDR   = r_udr;
    assign D2    = r_d2;
    assign D3    = r_d3;
    assign D4    = r_d4;
    assign MAG   = r_mag;
    assign VALID = r_valid;
    assign ERR   = r_err;
endmodule

// File: tb/tb_mc14433_bcd_reader.sv
// tb_mc14433_bcd_reader: table-driven and randomized frames checked against expectations
// derived from the decoding rules, plus hand-built fault, timeout and restart sequences.
module tb_mc14433_bcd_reader;
    logic        CP0 = 1'b0;
    logic        R_clock = 1'b0;
    logic        EOC = 1'b0;
    logic [4:1]  DS = '0;
    logic [3:0]  Q = '0;
    logic        HALF, POS, OVR, UDR, VALID, ERR;
    logic [3:0]  D2, D3, D4;
    logic [10:0] MAG;

    int checks = 0, errors = 0, n_valid = 0, n_err = 0, t_valid = 0, t_err = 0;
    logic        e_half = 0, e_pos = 0, e_ovr = 0, e_udr = 0;
    logic [3:0]  e_d2 = 0, e_d3 = 0, e_d4 = 0;
    logic [10:0] e_mag = 0;

    typedef struct packed {
        logic [3:0]  q1, d2, d3, d4;
        logic        v, half, pos, ovr, udr;
        logic [10:0] mag;
    } vec_t;
    vec_t tbl [10];

    mc14433_bcd_reader #(.TIMEOUT(16)) dut (
        .CP0(CP0), .R_clock(R_clock), .EOC(EOC), .DS(DS), .Q(Q),
        .HALF(HALF), .D2(D2), .D3(D3), .D4(D4), .POS(POS), .OVR(OVR), .UDR(UDR),
        .MAG(MAG), .VALID(VALID), .ERR(ERR)
    );

    always #5 CP0 = ~CP0;

    always @(negedge CP0) begin
        if (VALID) n_valid++;
        if (ERR) n_err++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name);
        chk({name, " HALF"}, int'(HALF), int'(e_half));
        chk({name, " POS"}, int'(POS), int'(e_pos));
        chk({name, " OVR"}, int'(OVR), int'(e_ovr));
        chk({name, " UDR"}, int'(UDR), int'(e_udr));
        chk({name, " D2"}, int'(D2), int'(e_d2));
        chk({name, " D3"}, int'(D3), int'(e_d3));
        chk({name, " D4"}, int'(D4), int'(e_d4));
        chk({name, " MAG"}, int'(MAG), int'(e_mag));
    endtask

    // Raw strobe rise at one falling edge; VALID/ERR must appear exactly 3 cycles later
    task automatic strobe(input logic [4:1] m, input logic [3:0] q, input bit ev, input bit ee,
                          input bit we = 1'b0);
        Q = q;
        @(negedge CP0);
        DS = m;
        if (we) EOC = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CP0);
            chk("VALID pulse", int'(VALID), (i == 3) ? int'(ev) : 0);
            chk("ERR pulse", int'(ERR), (i == 3) ? int'(ee) : 0);
            if (i == 3) begin
                DS = '0;
                EOC = 1'b0;
            end
        end
        t_valid += int'(ev);
        t_err += int'(ee);
    endtask

    task automatic eoc_pulse();
        @(negedge CP0);
        EOC = 1'b1;
        repeat (2) @(negedge CP0);
        EOC = 1'b0;
        repeat (2) @(negedge CP0);
        chk("ERR after EOC", int'(ERR), 0);
    endtask

    task automatic frame(input logic [3:0] q1, d2, d3, d4, input bit v);
        bit e2, e3, e4;
        e2 = d2 > 9;
        e3 = !e2 && d3 > 9;
        e4 = !e2 && !e3 && d4 > 9;
        eoc_pulse();
        strobe(4'b0001, q1, 1'b0, 1'b0);
        strobe(4'b0010, d2, 1'b0, e2);
        strobe(4'b0100, d3, 1'b0, e3);
        strobe(4'b1000, d4, v, e4);
    endtask

    task automatic expect_reading(input logic [3:0] q1, d2, d3, d4);
        e_half = !q1[3];
        e_pos  = q1[2];
        e_ovr  = q1[0] && !q1[3];
        e_udr  = q1[0] && q1[3];
        e_d2 = d2;
        e_d3 = d3;
        e_d4 = d4;
        e_mag = 11'((e_half ? 1000 : 0) + int'(d2) * 100 + int'(d3) * 10 + int'(d4));
    endtask

    initial begin
        tbl[0] = '{4'b0100, 4'd9, 4'd8, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1987};
        tbl[1] = '{4'b1001, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0};
        tbl[2] = '{4'b0101, 4'd9, 4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd1999};
        tbl[3] = '{4'b0000, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1123};
        tbl[4] = '{4'b1100, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd50};
        tbl[5] = '{4'b0110, 4'd4, 4'd5, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1456};
        tbl[6] = '{4'b1000, 4'hA, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
        tbl[7] = '{4'b1000, 4'd3, 4'hA, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
        tbl[8] = '{4'b1000, 4'd3, 4'd3, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
        tbl[9] = '{4'b1101, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11'd200};

        repeat (3) @(negedge CP0);
        chk_out("reset");
        chk("reset VALID", int'(VALID), 0);
        chk("reset ERR", int'(ERR), 0);
        R_clock = 1'b1;
        @(negedge CP0);

        for (int k = 0; k < 10; k++) begin
            frame(tbl[k].q1, tbl[k].d2, tbl[k].d3, tbl[k].d4, tbl[k].v);
            if (tbl[k].v) begin
                e_half = tbl[k].half;
                e_pos  = tbl[k].pos;
                e_ovr  = tbl[k].ovr;
                e_udr  = tbl[k].udr;
                e_d2 = tbl[k].d2;
                e_d3 = tbl[k].d3;
                e_d4 = tbl[k].d4;
                e_mag = tbl[k].mag;
            end
            chk_out($sformatf("vec%0d", k));
        end

        for (int k = 0; k < 24; k++) begin
            logic [3:0] q1, d2, d3, d4;
            bit v;
            q1 = 4'($urandom);
            d2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            d3 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            d4 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            v = d2 < 10 && d3 < 10 && d4 < 10;
            frame(q1, d2, d3, d4, v);
            if (v) expect_reading(q1, d2, d3, d4);
            chk_out($sformatf("rand%0d", k));
        end

        eoc_pulse();
        strobe(4'b0001, 4'b0100, 1'b0, 1'b0);
        strobe(4'b0100, 4'd5, 1'b0, 1'b1);
        chk_out("seq fault");

        eoc_pulse();
        strobe(4'b0001, 4'b0100, 1'b0, 1'b0);
        strobe(4'b0110, 4'd3, 1'b0, 1'b1);
        chk_out("two strobes");

        eoc_pulse();
        Q = 4'b0100;
        @(negedge CP0);
        DS = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CP0);
            if (i == 3) DS = '0;
            chk($sformatf("timeout ERR c%0d", i), int'(ERR), (i == 19) ? 1 : 0);
        end
        t_err++;
        strobe(4'b0001, 4'b0100, 1'b0, 1'b0);
        strobe(4'b0010, 4'd1, 1'b0, 1'b0);
        strobe(4'b0100, 4'd1, 1'b0, 1'b0);
        strobe(4'b1000, 4'd1, 1'b0, 1'b0);
        chk_out("idle after timeout");

        eoc_pulse();
        strobe(4'b0001, 4'b0000, 1'b0, 1'b0);
        strobe(4'b0010, 4'd1, 1'b0, 1'b0);
        frame(4'b0100, 4'd2, 4'd4, 4'd6, 1'b1);
        expect_reading(4'b0100, 4'd2, 4'd4, 4'd6);
        chk_out("restart");

        eoc_pulse();
        strobe(4'b0001, 4'b0000, 1'b0, 1'b0);
        strobe(4'b0010, 4'd3, 1'b0, 1'b0);
        strobe(4'b0100, 4'd2, 1'b0, 1'b0);
        strobe(4'b1000, 4'd1, 1'b1, 1'b0, 1'b1);
        expect_reading(4'b0000, 4'd3, 4'd2, 4'd1);
        chk_out("eoc with commit");
        strobe(4'b0001, 4'b0100, 1'b0, 1'b0);
        strobe(4'b0010, 4'd5, 1'b0, 1'b0);
        strobe(4'b0100, 4'd5, 1'b0, 1'b0);
        strobe(4'b1000, 4'd5, 1'b1, 1'b0);
        expect_reading(4'b0100, 4'd5, 4'd5, 4'd5);
        chk_out("armed after commit");

        eoc_pulse();
        strobe(4'b0001, 4'b0100, 1'b0, 1'b0);
        strobe(4'b0010, 4'd7, 1'b0, 1'b0);
        @(negedge CP0);
        R_clock = 1'b0;
        @(negedge CP0);
        R_clock = 1'b1;
        expect_reading(4'b1000, 4'd0, 4'd0, 4'd0);
        chk_out("mid reset");
        strobe(4'b0100, 4'd1, 1'b0, 1'b0);
        strobe(4'b1000, 4'd1, 1'b0, 1'b0);
        chk_out("after mid reset");

        repeat (4) @(negedge CP0);
        chk("VALID total", n_valid, t_valid);
        chk("ERR total", n_err, t_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
